// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit integer divider for DIV/DIVU.
// It uses a restoring radix-2 algorithm, one quotient bit per cycle.
// result_o = {remainder, quotient}; ready_o qualifies it for one cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration
// sequence and goes straight to DONE with the divide-by-zero result.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] rem_q, rem_d;       // partial remainder
    logic [31:0] quo_q, quo_d;       // dividend magnitude shifting out, quotient shifting in
    logic [31:0] dvs_q, dvs_d;       // divisor magnitude
    logic [63:0] result_q, result_d;

    logic [32:0] rem_sh_s;
    logic [32:0] diff_s;
    logic [31:0] step_rem_s;
    logic [31:0] step_quo_s;
    logic        quo_neg_s;
    logic        rem_neg_s;
    logic [63:0] final_s;

    // Magnitude of an operand; only negative values in signed mode are negated.
    // The most negative value maps to 0x80000000, which is its correct unsigned magnitude.
    function automatic logic [31:0] mag_f(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One restoring shift/subtract step, plus the sign-corrected final result.
    always_comb begin
        rem_sh_s = {rem_q, quo_q[31]};
        diff_s   = rem_sh_s - {1'b0, dvs_q};
        if (!diff_s[32]) begin
            step_rem_s = diff_s[31:0];
            step_quo_s = {quo_q[30:0], 1'b1};
        end else begin
            step_rem_s = rem_sh_s[31:0];
            step_quo_s = {quo_q[30:0], 1'b0};
        end
        quo_neg_s = sgn_q & (a_q[31] ^ b_q[31]);
        rem_neg_s = sgn_q & a_q[31];
        if (b_q == 32'd0) begin
            // Divide-by-zero: all-ones quotient, dividend passed through as remainder.
            final_s = {a_q, 32'hFFFF_FFFF};
        end else begin
            final_s[63:32] = rem_neg_s ? (32'd0 - step_rem_s) : step_rem_s;
            final_s[31:0]  = quo_neg_s ? (32'd0 - step_quo_s) : step_quo_s;
        end
    end

    // Next-state and datapath update for the IDLE/ON/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i && !annul_i) begin
                    a_d   = a_i;
                    b_d   = b_i;
                    sgn_d = signed_i;
                    cnt_d = 6'd0;
                    rem_d = 32'd0;
                    quo_d = mag_f(a_i, signed_i);
                    dvs_d = mag_f(b_i, signed_i);
`ifdef DIV_ZERO_FAST_EN
                    if (b_i == 32'd0) begin
                        state_d  = DONE;
                        result_d = {a_i, 32'hFFFF_FFFF};
                    end else begin
                        state_d = ON;
                    end
`else
                    state_d = ON;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        result_d = final_s;
                    end else begin
                        state_d = ON;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            sgn_q    <= 1'b0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    // Handshake to the pipeline: ready in DONE unless flushed, stall while incomplete.
    always_comb begin
        ready_o  = (state_q == DONE) && !annul_i;
        stall_o  = start_i & ~ready_o & ~annul_i;
        result_o = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit with hand-computed expected values.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int          n_vec;
    int          n_miss;
    logic [63:0] last_res;

    div_unit dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_STALL = 1;
`else
    localparam int ZERO_STALL = 33;
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Issue one division with start held until DONE; checks result, latency and handshake.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_stall, input bit scramble);
        int stalls;
        bit got;
        stalls = 0;
        got    = 1'b0;
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
        for (int cyc = 0; cyc < 100 && !got; cyc++) begin
            #1;
            if (ready_o) begin
                got = 1'b1;
                check_val({tag, "_stall_done"}, {63'd0, stall_o}, 64'd0);
                check_val({tag, "_result"}, result_o, exp);
            end else begin
                if (stall_o) stalls++;
                @(negedge clk);
                if (scramble) begin
                    a_i = $urandom;
                    b_i = $urandom;
                end
            end
        end
        check_val({tag, "_ready_seen"}, {63'd0, got}, 64'd1);
        check_val({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check_val({tag, "_ready_one_cycle"}, {63'd0, ready_o}, 64'd0);
        check_val({tag, "_result_hold"}, result_o, exp);
        last_res = exp;
    endtask

    // Watch for a number of cycles, checking that no result appears.
    task automatic expect_quiet(input string tag, input int cycles);
        int readies;
        readies = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (ready_o) readies++;
        end
        check_val({tag, "_no_ready"}, 64'(readies), 64'd0);
        check_val({tag, "_result_kept"}, result_o, last_res);
    endtask

    // Main stimulus sequence.
    initial begin
        n_vec    = 0;
        n_miss   = 0;
        last_res = 64'd0;
        resetn   = 1'b0;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        annul_i  = 1'b0;
        #1;
        check_val("rst_result", result_o, 64'd0);
        check_val("rst_ready", {63'd0, ready_o}, 64'd0);
        check_val("rst_stall_follows_start", {63'd0, stall_o}, 64'd1);
        start_i = 1'b0;
        #1;
        check_val("rst_stall_low", {63'd0, stall_o}, 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33, 1'b0);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b0);
        run_div("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33, 1'b0);
        run_div("divu_by0",    1'b0, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF, ZERO_STALL, 1'b0);
        run_div("div_m5_by0",  1'b1, 32'hFFFFFFFB,   32'd0,          64'hFFFFFFFB_FFFFFFFF, ZERO_STALL, 1'b0);
        run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33, 1'b0);
        run_div("divu_big_2",  1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33, 1'b0);
        run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33, 1'b0);
        run_div("divu_5_10",   1'b0, 32'd5,          32'd10,         64'h00000005_00000000, 33, 1'b0);
        run_div("divu_max_max",1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001, 33, 1'b0);
        run_div("div_scramble",1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33, 1'b1);

        // Flush at ON cycle 10 abandons the division.
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd50;
        b_i      = 32'd5;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check_val("annul_stall", {63'd0, stall_o}, 64'd0);
        check_val("annul_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        expect_quiet("annul", 40);
        run_div("divu_9_4",    1'b0, 32'd9,          32'd4,          64'h00000001_00000002, 33, 1'b0);

        // start and annul together in IDLE must not launch a division.
        @(negedge clk);
        start_i = 1'b1;
        annul_i = 1'b1;
        a_i     = 32'd100;
        b_i     = 32'd7;
        #1;
        check_val("idle_annul_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        expect_quiet("idle_annul", 40);

        // Reset mid-division clears outputs and abandons the operation.
        @(negedge clk);
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd1000;
        b_i      = 32'd3;
        repeat (15) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_val("midrst_result", result_o, 64'd0);
        check_val("midrst_ready", {63'd0, ready_o}, 64'd0);
        check_val("midrst_stall", {63'd0, stall_o}, 64'd1);
        last_res = 64'd0;
        start_i  = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        expect_quiet("post_rst", 40);
        run_div("divu_after_rst", 1'b0, 32'd100,     32'd7,          64'h00000002_0000000E, 33, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
